// File: rtl/gr_wb_arbiter.sv
// Write-back arbiter for the 16x32 register file: two requester FIFOs feed one
// registered write port through a round-robin scheduler; busy[] flags pending writes.
module gr_wb_arbiter #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREG  = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              flush,
    input  logic [1:0]                        in_valid,
    output logic [1:0]                        in_ready,
    input  logic [1:0][$clog2(NREG)-1:0]      in_rd,
    input  logic [1:0][XLEN-1:0]              in_data,
    output logic                              w_en,
    output logic [$clog2(NREG)-1:0]           rd,
    output logic [XLEN-1:0]                   x_rd,
    output logic [NREG-1:0]                   busy
);

    localparam int unsigned RDW = $clog2(NREG);
    localparam int unsigned PW  = $clog2(DEPTH);
    localparam int unsigned CW  = PW + 1;

    logic [RDW-1:0]  r_qrd   [2][DEPTH];
    logic [XLEN-1:0] r_qdata [2][DEPTH];
    logic [PW-1:0]   r_wp    [2];
    logic [PW-1:0]   r_rp    [2];
    logic [CW-1:0]   r_cnt   [2];
    logic            r_rr;
    logic            r_wen;
    logic [RDW-1:0]  r_rd;
    logic [XLEN-1:0] r_xrd;

    logic [1:0]      w_ne;
    logic [1:0]      w_pop;
    logic [1:0]      w_store;
    logic            w_sel;
    logic            w_pop_any;
    logic [NREG-1:0] w_busy;

    always_comb begin
        for (int unsigned i = 0; i < 2; i++) begin
            in_ready[i] = (r_cnt[i] != CW'(DEPTH));
            w_ne[i]     = (r_cnt[i] != '0);
            // x0 writes complete the handshake but are never stored
            w_store[i]  = reset && !flush && in_valid[i] && in_ready[i] && (in_rd[i] != '0);
        end
    end

    always_comb begin
        w_pop     = '0;
        w_pop_any = |w_ne;
        if (w_ne[0] && w_ne[1]) begin
            w_sel = r_rr;
        end else begin
            w_sel = w_ne[1];
        end
        w_pop[w_sel] = w_pop_any;
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < 2; i++) begin
            if (w_store[i]) begin
                r_qrd[i][r_wp[i]]   <= in_rd[i];
                r_qdata[i][r_wp[i]] <= in_data[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < 2; i++) begin
                r_wp[i]  <= '0;
                r_rp[i]  <= '0;
                r_cnt[i] <= '0;
            end
            r_rr  <= 1'b0;
            r_wen <= 1'b0;
            r_rd  <= '0;
            r_xrd <= '0;
        end else if (flush) begin
            for (int unsigned i = 0; i < 2; i++) begin
                r_wp[i]  <= '0;
                r_rp[i]  <= '0;
                r_cnt[i] <= '0;
            end
            r_wen <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < 2; i++) begin
                if (w_store[i]) begin
                    r_wp[i] <= r_wp[i] + PW'(1);
                end
                if (w_pop[i]) begin
                    r_rp[i] <= r_rp[i] + PW'(1);
                end
                r_cnt[i] <= r_cnt[i] + CW'(w_store[i]) - CW'(w_pop[i]);
            end
            r_wen <= w_pop_any;
            if (w_pop_any) begin
                r_rd  <= r_qrd[w_sel][r_rp[w_sel]];
                r_xrd <= r_qdata[w_sel][r_rp[w_sel]];
            end
            // pointer only moves when there was an actual contest
            if (w_ne[0] && w_ne[1]) begin
                r_rr <= ~w_sel;
            end
        end
    end

    always_comb begin
        w_busy = '0;
        for (int unsigned i = 0; i < 2; i++) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                if (CW'(PW'(PW'(k) - r_rp[i])) < r_cnt[i]) begin
                    w_busy[r_qrd[i][k]] = 1'b1;
                end
            end
        end
        if (r_wen) begin
            w_busy[r_rd] = 1'b1;
        end
        w_busy[0] = 1'b0;
    end

    assign w_en = r_wen;
    assign rd   = r_rd;
    assign x_rd = r_xrd;
    assign busy = w_busy;

endmodule

// File: tb/tb_gr_wb_arbiter.sv
// Bench for gr_wb_arbiter: vector table, directed corner sequences and a
// randomized run checked against a queue-based reference model.
module tb_gr_wb_arbiter;

    localparam int XLEN  = 32;
    localparam int NREG  = 16;
    localparam int DEPTH = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              flush;
    logic [1:0]        in_valid;
    logic [1:0]        in_ready;
    logic [1:0][3:0]   in_rd;
    logic [1:0][31:0]  in_data;
    logic              w_en;
    logic [3:0]        rd;
    logic [31:0]       x_rd;
    logic [15:0]       busy;

    always #5 clk = ~clk;

    gr_wb_arbiter #(.XLEN(XLEN), .NREG(NREG), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_data(in_data),
        .w_en(w_en), .rd(rd), .x_rd(x_rd), .busy(busy)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: per-requester queues, RR pointer and the staged write.
    typedef struct packed {
        logic [3:0]  r;
        logic [31:0] d;
    } ent_t;

    ent_t        mq0[$];
    ent_t        mq1[$];
    int          m_rr    = 0;
    bit          m_live  = 0;
    logic        m_wen   = 1'b0;
    logic [3:0]  m_rd    = '0;
    logic [31:0] m_xd    = '0;

    function automatic logic [15:0] model_busy();
        logic [15:0] b = '0;
        foreach (mq0[k]) b[mq0[k].r] = 1'b1;
        foreach (mq1[k]) b[mq1[k].r] = 1'b1;
        if (m_wen) b[m_rd] = 1'b1;
        b[0] = 1'b0;
        return b;
    endfunction

    task automatic check_model();
        logic [1:0] er;
        if (!m_live) return;
        er[0] = (mq0.size() < DEPTH);
        er[1] = (mq1.size() < DEPTH);
        chk("m_ready", 64'(in_ready), 64'(er));
        chk("m_wen",   64'(w_en),     64'(m_wen));
        chk("m_rd",    64'(rd),       64'(m_rd));
        chk("m_xrd",   64'(x_rd),     64'(m_xd));
        chk("m_busy",  64'(busy),     64'(model_busy()));
    endtask

    task automatic model_step();
        int   s0, s1, sel;
        ent_t e;
        if (!reset) begin
            mq0.delete(); mq1.delete();
            m_rr = 0; m_wen = 1'b0; m_rd = '0; m_xd = '0; m_live = 1;
        end else if (flush) begin
            mq0.delete(); mq1.delete();
            m_wen = 1'b0;
        end else begin
            s0 = mq0.size();
            s1 = mq1.size();
            sel = -1;
            if (s0 > 0 && s1 > 0) begin
                sel  = m_rr;
                m_rr = 1 - sel;
            end else if (s0 > 0) sel = 0;
            else if (s1 > 0) sel = 1;
            m_wen = (sel >= 0);
            if (sel == 0) begin
                e = mq0.pop_front(); m_rd = e.r; m_xd = e.d;
            end else if (sel == 1) begin
                e = mq1.pop_front(); m_rd = e.r; m_xd = e.d;
            end
            if (in_valid[0] && s0 < DEPTH && in_rd[0] != 4'd0) mq0.push_back({in_rd[0], in_data[0]});
            if (in_valid[1] && s1 < DEPTH && in_rd[1] != 4'd0) mq1.push_back({in_rd[1], in_data[1]});
        end
    endtask

    task automatic drive(input logic rst, input logic fl, input logic [1:0] v,
                         input logic [3:0] r0, input logic [3:0] r1,
                         input logic [31:0] d0, input logic [31:0] d1);
        reset = rst; flush = fl; in_valid = v;
        in_rd[0] = r0; in_rd[1] = r1; in_data[0] = d0; in_data[1] = d1;
    endtask

    // Checks pre-edge state against the model, advances the model, then crosses one edge.
    task automatic cycle();
        @(negedge clk);
        check_model();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b1, 1'b0, 2'b00, 4'd0, 4'd0, 32'd0, 32'd0);
    endtask

    typedef struct {
        logic        rst, fl;
        logic [1:0]  v;
        logic [3:0]  r0, r1;
        logic [31:0] d0, d1;
        logic [1:0]  e_rdy;
        logic        e_wen;
        logic [3:0]  e_rd;
        logic [31:0] e_x;
        logic [15:0] e_busy;
    } vec_t;

    function automatic vec_t mkv(input logic rst, input logic fl, input logic [1:0] v,
                                 input logic [3:0] r0, input logic [3:0] r1,
                                 input logic [31:0] d0, input logic [31:0] d1,
                                 input logic [1:0] e_rdy, input logic e_wen, input logic [3:0] e_rd,
                                 input logic [31:0] e_x, input logic [15:0] e_busy);
        vec_t t;
        t.rst = rst; t.fl = fl; t.v = v; t.r0 = r0; t.r1 = r1; t.d0 = d0; t.d1 = d1;
        t.e_rdy = e_rdy; t.e_wen = e_wen; t.e_rd = e_rd; t.e_x = e_x; t.e_busy = e_busy;
        return t;
    endfunction

    vec_t tbl[13];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int          hits;
        bit          got_full;
        logic [3:0]  seq[6];

        drive(1'b0, 1'b0, 2'b00, 4'd0, 4'd0, 32'd0, 32'd0);

        // rst fl v     r0     r1     d0            d1          | rdy   wen   rd     x             busy
        tbl[0]  = mkv(1'b0, 1'b0, 2'b00, 4'd0, 4'd0, 32'h0,        32'h0,    2'b11, 1'b0, 4'd0, 32'h0,        16'h0000);
        tbl[1]  = mkv(1'b1, 1'b0, 2'b00, 4'd0, 4'd0, 32'h0,        32'h0,    2'b11, 1'b0, 4'd0, 32'h0,        16'h0000);
        tbl[2]  = mkv(1'b1, 1'b0, 2'b01, 4'd5, 4'd0, 32'hDEADBEEF, 32'h0,    2'b11, 1'b0, 4'd0, 32'h0,        16'h0020);
        tbl[3]  = mkv(1'b1, 1'b0, 2'b00, 4'd0, 4'd0, 32'h0,        32'h0,    2'b11, 1'b1, 4'd5, 32'hDEADBEEF, 16'h0020);
        tbl[4]  = mkv(1'b1, 1'b0, 2'b00, 4'd0, 4'd0, 32'h0,        32'h0,    2'b11, 1'b0, 4'd5, 32'hDEADBEEF, 16'h0000);
        tbl[5]  = mkv(1'b1, 1'b0, 2'b10, 4'd0, 4'd0, 32'h0,        32'h1234, 2'b11, 1'b0, 4'd5, 32'hDEADBEEF, 16'h0000);
        tbl[6]  = mkv(1'b1, 1'b0, 2'b00, 4'd0, 4'd0, 32'h0,        32'h0,    2'b11, 1'b0, 4'd5, 32'hDEADBEEF, 16'h0000);
        tbl[7]  = mkv(1'b1, 1'b0, 2'b11, 4'd3, 4'd7, 32'h33,       32'h77,   2'b11, 1'b0, 4'd5, 32'hDEADBEEF, 16'h0088);
        tbl[8]  = mkv(1'b1, 1'b0, 2'b00, 4'd0, 4'd0, 32'h0,        32'h0,    2'b11, 1'b1, 4'd3, 32'h33,       16'h0088);
        tbl[9]  = mkv(1'b1, 1'b0, 2'b00, 4'd0, 4'd0, 32'h0,        32'h0,    2'b11, 1'b1, 4'd7, 32'h77,       16'h0080);
        tbl[10] = mkv(1'b1, 1'b0, 2'b00, 4'd0, 4'd0, 32'h0,        32'h0,    2'b11, 1'b0, 4'd7, 32'h77,       16'h0000);
        tbl[11] = mkv(1'b1, 1'b1, 2'b01, 4'd2, 4'd0, 32'h22,       32'h0,    2'b11, 1'b0, 4'd7, 32'h77,       16'h0000);
        tbl[12] = mkv(1'b1, 1'b0, 2'b00, 4'd0, 4'd0, 32'h0,        32'h0,    2'b11, 1'b0, 4'd7, 32'h77,       16'h0000);

        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].rst, tbl[i].fl, tbl[i].v, tbl[i].r0, tbl[i].r1, tbl[i].d0, tbl[i].d1);
            cycle();
            chk($sformatf("tbl%0d_ready", i), 64'(in_ready), 64'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d_wen", i),   64'(w_en),     64'(tbl[i].e_wen));
            chk($sformatf("tbl%0d_rd", i),    64'(rd),       64'(tbl[i].e_rd));
            chk($sformatf("tbl%0d_xrd", i),   64'(x_rd),     64'(tbl[i].e_x));
            chk($sformatf("tbl%0d_busy", i),  64'(busy),     64'(tbl[i].e_busy));
        end

        // Idle after reset for 10 cycles.
        drive(1'b0, 1'b0, 2'b00, 4'd0, 4'd0, 32'd0, 32'd0);
        cycle();
        idle();
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk("idle_state", 64'({in_ready, w_en, busy}), 64'({2'b11, 1'b0, 16'h0000}));
        end

        // Round-robin interleave of two preloaded streams.
        seq[0] = 4'd1; seq[1] = 4'd9; seq[2] = 4'd2; seq[3] = 4'd10; seq[4] = 4'd3; seq[5] = 4'd11;
        drive(1'b1, 1'b0, 2'b11, 4'd1, 4'd9, 32'h100, 32'h900);
        cycle();
        chk("rr_first_wen", 64'(w_en), 64'(0));
        for (int k = 1; k < 3; k++) begin
            drive(1'b1, 1'b0, 2'b11, 4'(k + 1), 4'(k + 9), 32'(256 * (k + 1)), 32'(256 * (k + 9)));
            cycle();
            chk($sformatf("rr_seq%0d", k - 1), 64'({w_en, rd}), 64'({1'b1, seq[k - 1]}));
        end
        idle();
        for (int k = 2; k < 6; k++) begin
            cycle();
            chk($sformatf("rr_seq%0d", k), 64'({w_en, rd}), 64'({1'b1, seq[k]}));
        end
        cycle();
        chk("rr_drained", 64'({w_en, busy}), 64'(0));

        // Fill req0 by keeping both requesters pushing; a push at full must be dropped.
        drive(1'b0, 1'b0, 2'b00, 4'd0, 4'd0, 32'd0, 32'd0);
        cycle();
        got_full = 0;
        for (int c = 0; c < 40 && !got_full; c++) begin
            drive(1'b1, 1'b0, 2'b11, 4'(1 + c % 6), 4'(8 + c % 6), $urandom, $urandom);
            cycle();
            if (in_ready[0] == 1'b0) got_full = 1;
        end
        chk("fill_ready0_low", 64'(got_full), 64'(1));
        drive(1'b1, 1'b0, 2'b01, 4'd15, 4'd0, 32'hF00D, 32'd0);
        cycle();
        hits = 0;
        if (w_en && rd == 4'd15) hits++;
        idle();
        for (int c = 0; c < 12; c++) begin
            cycle();
            if (w_en && rd == 4'd15) hits++;
        end
        chk("full_push_rejected", 64'(hits), 64'(0));
        chk("full_drained_ready", 64'({in_ready, busy}), 64'({2'b11, 16'h0000}));

        // Flush with queued writes, then reset mid-stream.
        drive(1'b0, 1'b0, 2'b00, 4'd0, 4'd0, 32'd0, 32'd0);
        cycle();
        for (int c = 0; c < 2; c++) begin
            drive(1'b1, 1'b0, 2'b11, 4'd4, 4'd12, 32'h44, 32'hCC);
            cycle();
        end
        chk("pre_flush_busy", 64'(busy), 64'(16'h1010));
        drive(1'b1, 1'b1, 2'b11, 4'd6, 4'd13, 32'h66, 32'hDD);
        cycle();
        chk("flush_state", 64'({in_ready, w_en, busy}), 64'({2'b11, 1'b0, 16'h0000}));
        idle();
        hits = 0;
        for (int c = 0; c < 5; c++) begin
            cycle();
            if (w_en || busy != 16'h0) hits++;
        end
        chk("post_flush_quiet", 64'(hits), 64'(0));
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 1'b0, 2'b11, 4'(c + 1), 4'(c + 8), $urandom, $urandom);
            cycle();
        end
        drive(1'b0, 1'b1, 2'b11, 4'd5, 4'd6, 32'h55, 32'h66);
        cycle();
        chk("midreset_state", 64'({in_ready, w_en, rd, busy}), 64'({2'b11, 1'b0, 4'd0, 16'h0000}));
        chk("midreset_xrd", 64'(x_rd), 64'(0));

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            drive(($urandom_range(0, 199) != 0), ($urandom_range(0, 31) == 0), 2'($urandom),
                  4'($urandom), 4'($urandom), $urandom, $urandom);
            cycle();
        end
        idle();
        for (int c = 0; c < 12; c++) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
